reg_file_rw: RTL and testbench

REG_FILE_RW -- requirements
Module: reg_file_rw

---
 rtl/reg_file_rw.sv | 54 +++++
 tb/tb_reg_file_rw.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/reg_file_rw.sv
// 32 x 32-bit register file with registered dual read ports and a write-commit counter.
// Optional macro REGFILE_BYPASS_EN selects write-first read-during-write (default: read-first).
module reg_file_rw (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        RegWre,
   input  logic [4:0]  WriteReg,
   input  logic [31:0] WriteData,
   input  logic        RdEn,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   output logic [31:0] ADR,
   output logic [31:0] BDR,
   output logic [7:0]  WbCount
);

   logic [31:0] regs [32];
   logic        wr_en;
   logic [31:0] a_nxt;
   logic [31:0] b_nxt;

   // Writes to $0 are discarded so that register never leaves zero.
   assign wr_en = RegWre && (WriteReg != 5'd0);

   always_comb begin
      a_nxt = regs[rs];
      b_nxt = regs[rt];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (WriteReg == rs)) a_nxt = WriteData;
      if (wr_en && (WriteReg == rt)) b_nxt = WriteData;
`endif
      if (rs == 5'd0) a_nxt = 32'd0;
      if (rt == 5'd0) b_nxt = 32'd0;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
         ADR     <= 32'd0;
         BDR     <= 32'd0;
         WbCount <= 8'd0;
      end else begin
         if (wr_en) begin
            regs[WriteReg] <= WriteData;
            WbCount        <= WbCount + 8'd1;
         end
         if (RdEn) begin
            ADR <= a_nxt;
            BDR <= b_nxt;
         end
      end
   end

endmodule

// File: tb/tb_reg_file_rw.sv
// Directed self-checking bench for reg_file_rw; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file_rw;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        RegWre;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic        RdEn;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [31:0] ADR;
   logic [31:0] BDR;
   logic [7:0]  WbCount;

   int checks = 0;
   int errors = 0;

   reg_file_rw dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .RegWre   (RegWre),
      .WriteReg (WriteReg),
      .WriteData(WriteData),
      .RdEn     (RdEn),
      .rs       (rs),
      .rt       (rt),
      .ADR      (ADR),
      .BDR      (BDR),
      .WbCount  (WbCount)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      RegWre = 1'b1; WriteReg = a; WriteData = d;
      tick();
      RegWre = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, input logic [4:0] b);
      RdEn = 1'b1; rs = a; rt = b;
      tick();
      RdEn = 1'b0;
   endtask

   logic bypass;

   initial begin
`ifdef REGFILE_BYPASS_EN
      bypass = 1'b1;
`else
      bypass = 1'b0;
`endif
      Reset = 1'b1; RegWre = 1'b0; WriteReg = '0; WriteData = '0;
      RdEn = 1'b0; rs = '0; rt = '0;
      tick();
      Reset = 1'b0;
      check("rst_adr", ADR, 32'd0);
      check("rst_bdr", BDR, 32'd0);
      check("rst_cnt", {24'd0, WbCount}, 32'd0);

      rd(5'd3, 5'd31);
      check("rd0_adr", ADR, 32'd0);
      check("rd0_bdr", BDR, 32'd0);
      check("rd0_cnt", {24'd0, WbCount}, 32'd0);

      wr(5'd5, 32'h12345678);
      rd(5'd5, 5'd0);
      check("wr5_adr", ADR, 32'h12345678);
      check("wr5_bdr", BDR, 32'd0);
      check("wr5_cnt", {24'd0, WbCount}, 32'd1);

      wr(5'd0, 32'hFFFFFFFF);
      rd(5'd0, 5'd5);
      check("wr0_adr", ADR, 32'd0);
      check("wr0_bdr", BDR, 32'h12345678);
      check("wr0_cnt", {24'd0, WbCount}, 32'd1);

      rd(5'd5, 5'd5);
      check("same_adr", ADR, 32'h12345678);
      check("same_bdr", BDR, 32'h12345678);

      // Read-during-write on both ports
      wr(5'd7, 32'hA);
      RegWre = 1'b1; WriteReg = 5'd7; WriteData = 32'hB;
      RdEn = 1'b1; rs = 5'd7; rt = 5'd7;
      tick();
      RegWre = 1'b0; RdEn = 1'b0;
      check("rdw_adr", ADR, bypass ? 32'hB : 32'hA);
      check("rdw_bdr", BDR, bypass ? 32'hB : 32'hA);
      check("rdw_cnt", {24'd0, WbCount}, 32'd3);
      rd(5'd7, 5'd7);
      check("rdw_next", ADR, 32'hB);

      RegWre = 1'b1; WriteReg = 5'd7; WriteData = 32'hC;
      RdEn = 1'b1; rs = 5'd0; rt = 5'd7;
      tick();
      RegWre = 1'b0; RdEn = 1'b0;
      check("rdw0_adr", ADR, 32'd0);
      check("rdw0_bdr", BDR, bypass ? 32'hC : 32'hB);
      rd(5'd0, 5'd7);
      check("rdw0_next", BDR, 32'hC);

      // Output hold while RdEn is low
      wr(5'd9, 32'h55);
      rd(5'd9, 5'd0);
      check("hold_load", ADR, 32'h55);
      wr(5'd9, 32'h66);
      check("hold_a", ADR, 32'h55);
      tick();
      check("hold_b", ADR, 32'h55);
      rd(5'd9, 5'd0);
      check("hold_new", ADR, 32'h66);
      check("hold_cnt", {24'd0, WbCount}, 32'd6);

      for (int i = 0; i < 250; i++) wr(5'd1, 32'(i));
      check("wrap_cnt", {24'd0, WbCount}, 32'd0);
      for (int i = 0; i < 6; i++) wr(5'd1, 32'(i + 1000));
      check("wrap_cnt2", {24'd0, WbCount}, 32'd6);
      rd(5'd1, 5'd9);
      check("wrap_r1", ADR, 32'd1005);

      // Reset wins over a simultaneous write and read
      Reset = 1'b1; RegWre = 1'b1; WriteReg = 5'd2; WriteData = 32'hDEAD;
      RdEn = 1'b1; rs = 5'd2; rt = 5'd1;
      tick();
      Reset = 1'b0; RegWre = 1'b0; RdEn = 1'b0;
      check("rstw_adr", ADR, 32'd0);
      check("rstw_bdr", BDR, 32'd0);
      check("rstw_cnt", {24'd0, WbCount}, 32'd0);
      rd(5'd2, 5'd1);
      check("rstw_r2", ADR, 32'd0);
      check("rstw_r1", BDR, 32'd0);
      check("rstw_cnt2", {24'd0, WbCount}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
